// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a shared modular multiplier.
// Optional per-op watchdog with me_err output: define MOD_EXP_TIMEOUT_EN.
module mod_exp_ctrl #(
  parameter int WIDTH       = 2048,
  parameter int EXP_WIDTH   = 2048,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 me_rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     n,
  output logic                 busy,
  output logic                 me_finish,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     mm_x,
  output logic [WIDTH-1:0]     mm_y,
  output logic [WIDTH-1:0]     mm_n,
  output logic                 mm_rst,
`ifdef MOD_EXP_TIMEOUT_EN
  output logic                 me_err,
`endif
  input  logic                 mm_finish,
  input  logic [WIDTH-1:0]     mm_result
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SCAN = 3'd1, S_SQ = 3'd2, S_CHK = 3'd3,
    S_MU = 3'd4, S_NEXT = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [WIDTH-1:0]     base_r, acc_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 bit_s, idx_zero_s, timeout_s;

  assign bit_s      = exp_r[idx_r];
  assign idx_zero_s = (idx_r == IDX_ZERO);

`ifdef MOD_EXP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_r;

  assign timeout_s = ((state_r == S_SQ) || (state_r == S_MU)) && !mm_finish &&
                     (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Per-op cycle counter, restarted whenever a multiplier op is launched.
  always_ff @(posedge clk) begin
    if (me_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_nxt_s == S_SQ || state_nxt_s == S_MU) &&
                 state_r != S_SQ && state_r != S_MU) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_SQ || state_r == S_MU) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (me_rst) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) state_nxt_s = S_SCAN;
        else       state_nxt_s = state_r;
      end
      S_SCAN: begin
        if (idx_zero_s)  state_nxt_s = S_DONE;
        else if (bit_s)  state_nxt_s = S_SQ;
        else             state_nxt_s = S_SCAN;
      end
      S_SQ: begin
        if (mm_finish)      state_nxt_s = S_CHK;
        else if (timeout_s) state_nxt_s = S_DONE;
        else                state_nxt_s = S_SQ;
      end
      S_CHK: begin
        if (bit_s) state_nxt_s = S_MU;
        else       state_nxt_s = S_NEXT;
      end
      S_MU: begin
        if (mm_finish)      state_nxt_s = S_NEXT;
        else if (timeout_s) state_nxt_s = S_DONE;
        else                state_nxt_s = S_MU;
      end
      S_NEXT: begin
        if (idx_zero_s) state_nxt_s = S_DONE;
        else            state_nxt_s = S_SQ;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Datapath, multiplier handshake and registered outputs.
  always_ff @(posedge clk) begin
    if (me_rst) begin
      busy <= 1'b0;  me_finish <= 1'b0;  result <= {WIDTH{1'b0}};
      mm_x <= {WIDTH{1'b0}};  mm_y <= {WIDTH{1'b0}};  mm_n <= {WIDTH{1'b0}};
      mm_rst <= 1'b1;
      base_r <= {WIDTH{1'b0}};  acc_r <= {WIDTH{1'b0}};
      exp_r <= {EXP_WIDTH{1'b0}};  idx_r <= IDX_ZERO;
`ifdef MOD_EXP_TIMEOUT_EN
      me_err <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_r <= base;  exp_r <= exp;  mm_n <= n;
            idx_r <= IDX_TOP;  acc_r <= ONE;
            busy <= 1'b1;  me_finish <= 1'b0;
`ifdef MOD_EXP_TIMEOUT_EN
            me_err <= 1'b0;
`endif
          end
        end
        S_SCAN: begin
          if (bit_s) begin
            acc_r <= base_r;
            if (idx_zero_s) begin
              result <= base_r;
            end else begin
              idx_r <= idx_r - IDX_ONE;
              mm_x <= base_r;  mm_y <= base_r;  mm_rst <= 1'b0;
            end
          end else if (idx_zero_s) begin
            result <= ONE;
          end else begin
            idx_r <= idx_r - IDX_ONE;
          end
        end
        S_SQ, S_MU: begin
          if (mm_finish) begin
            acc_r <= mm_result;  mm_rst <= 1'b1;
          end else if (timeout_s) begin
            mm_rst <= 1'b1;  result <= {WIDTH{1'b0}};
`ifdef MOD_EXP_TIMEOUT_EN
            me_err <= 1'b1;
`endif
          end
        end
        S_CHK: begin
          if (bit_s) begin
            mm_x <= acc_r;  mm_y <= base_r;  mm_rst <= 1'b0;
          end
        end
        S_NEXT: begin
          if (idx_zero_s) begin
            result <= acc_r;
          end else begin
            idx_r <= idx_r - IDX_ONE;
            mm_x <= acc_r;  mm_y <= acc_r;  mm_rst <= 1'b0;
          end
        end
        default: mm_rst <= 1'b1;
      endcase
      if (state_nxt_s == S_DONE && state_r != S_DONE) begin
        busy <= 1'b0;  me_finish <= 1'b1;
      end
    end
  end

endmodule
